// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - ce_pix-gated raster timing generator with runtime sync offsets
// Optional raster line interrupt enabled by defining VIDEO_TIMING_LINE_IRQ_EN.
module video_timing_gen #(
  parameter int HW         = 9,
  parameter int VW         = 9,
  parameter int CW         = 12,
  parameter int H_TOTAL    = 396,
  parameter int H_ACT_BEG  = 25,
  parameter int H_ACT_END  = 265,
  parameter int H_ORIGIN   = 24,
  parameter int H_SYNC_BEG = 320,
  parameter int H_SYNC_LEN = 31,
  parameter int V_TOTAL    = 256,
  parameter int V_ACT_END  = 224,
  parameter int V_SYNC_BEG = 226,
  parameter int V_SYNC_LEN = 5,
  parameter int HOFFW      = 5,
  parameter int VOFFW      = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ce_pix,
  input  logic signed [HOFFW-1:0] hoffs,
  input  logic signed [VOFFW-1:0] voffs,
  input  logic [VW-1:0]           irq_line,
  input  logic [CW-1:0]           rgb_in,
  output logic [HW-1:0]           hpos,
  output logic [VW-1:0]           vpos,
  output logic [CW-1:0]           rgb_out,
  output logic                    hblank,
  output logic                    vblank,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    line_start,
  output logic                    frame_start,
  output logic                    line_irq
);
  localparam logic signed [HW+1:0] HSB_NOM = (HW+2)'(H_SYNC_BEG);
  localparam logic signed [HW+1:0] HSB_MAX = (HW+2)'(H_TOTAL - H_SYNC_LEN);
  localparam logic signed [HW+1:0] HS_LEN  = (HW+2)'(H_SYNC_LEN);
  localparam logic signed [VW+1:0] VSB_NOM = (VW+2)'(V_SYNC_BEG);
  localparam logic signed [VW+1:0] VSB_MAX = (VW+2)'(V_TOTAL - V_SYNC_LEN);
  localparam logic signed [VW+1:0] VS_LEN  = (VW+2)'(V_SYNC_LEN);

  logic [HW-1:0]           hcnt;
  logic [VW-1:0]           vcnt;
  logic signed [HOFFW-1:0] hoff_l;
  logic signed [VOFFW-1:0] voff_l;
  logic signed [HW+1:0]    hsb_raw, hsb, hx;
  logic signed [VW+1:0]    vsb_raw, vsb, vx;
  logic                    h_last, v_last, hsync_d, vsync_d;

  assign h_last = (hcnt == HW'(H_TOTAL - 1));
  assign v_last = (vcnt == VW'(V_TOTAL - 1));
  assign hpos   = hcnt - HW'(H_ORIGIN);
  assign vpos   = vcnt;
  assign hx     = $signed({2'b00, hcnt});
  assign vx     = $signed({2'b00, vcnt});

  // Sync start is widened by two bits so a negative offset cannot wrap before clamping.
  always_comb begin
    hsb_raw = HSB_NOM + $signed({{(HW+2-HOFFW){hoff_l[HOFFW-1]}}, hoff_l});
    vsb_raw = VSB_NOM + $signed({{(VW+2-VOFFW){voff_l[VOFFW-1]}}, voff_l});
    hsb = hsb_raw;
    if (hsb_raw[HW+1])          hsb = '0;
    else if (hsb_raw > HSB_MAX) hsb = HSB_MAX;
    vsb = vsb_raw;
    if (vsb_raw[VW+1])          vsb = '0;
    else if (vsb_raw > VSB_MAX) vsb = VSB_MAX;
    hsync_d = (hx >= hsb) && (hx < hsb + HS_LEN);
    vsync_d = (vx >= vsb) && (vx < vsb + VS_LEN);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hoff_l      <= '0;
      voff_l      <= '0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      rgb_out     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce_pix) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
      // Offsets only take effect on a frame boundary so a frame never has split sync.
      if (h_last && v_last) begin
        hoff_l <= hoffs;
        voff_l <= voffs;
      end
      hblank      <= (hcnt < HW'(H_ACT_BEG)) || (hcnt >= HW'(H_ACT_END));
      vblank      <= (vcnt >= VW'(V_ACT_END));
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      rgb_out     <= (hblank || vblank) ? '0 : rgb_in;
      line_start  <= h_last;
      frame_start <= h_last && v_last;
    end
  end

`ifdef VIDEO_TIMING_LINE_IRQ_EN
  logic [VW-1:0] vnext;
  assign vnext = v_last ? '0 : vcnt + 1'b1;

  always_ff @(posedge clk_sys) begin
    if (!reset_n)    line_irq <= 1'b0;
    else if (ce_pix) line_irq <= h_last && (vnext == irq_line);
  end
`else
  logic unused_irq_line;
  assign unused_irq_line = ^irq_line;
  assign line_irq = 1'b0;
`endif
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the core-local fixed-mode raster timing generator.
- Runs on the system clock and is gated by a pixel clock-enable, rather than clocking directly on the pixel clock.
- Produces H/V counters, game-space pixel coordinates, blanking, sync with runtime position offsets, frame/line strobes, and a blanked, registered RGB output.
- Sits between the game core (consumes HPOS/VPOS, supplies RGB) and arcade_video.

Parameters:
- HW, 9: width of H counter and HPOS.
- VW, 9: width of V counter and VPOS.
- CW, 12: RGB bus width.
- H_TOTAL, 396: pixels per line.
- H_ACT_BEG, 25: first active hcnt.
- H_ACT_END, 265: first blanked hcnt after active.
- H_ORIGIN, 24: hcnt mapped to HPOS=0.
- H_SYNC_BEG, 320: nominal hsync start.
- H_SYNC_LEN, 31: hsync width in pixels.
- V_TOTAL, 256: lines per frame.
- V_ACT_END, 224: first blanked line; active lines are 0..V_ACT_END-1.
- V_SYNC_BEG, 226: nominal vsync start line.
- V_SYNC_LEN, 5: vsync width in lines.
- HOFFW, 5: signed H offset width.
- VOFFW, 4: signed V offset width.

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: synchronous reset, active low.
- ce_pix, in, 1: pixel enable. All counter/output updates occur only on clk_sys edges with ce_pix=1.
- hoffs, in, HOFFW: signed hsync offset.
- voffs, in, VOFFW: signed vsync offset.
- irq_line, in, VW: raster IRQ line (optional feature only).
- rgb_in, in, CW: pixel colour from the core.
- hpos, out, HW: hcnt - H_ORIGIN, modulo 2^HW.
- vpos, out, VW: vcnt.
- rgb_out, out, CW: registered RGB, forced 0 while blanked.
- hblank, out, 1.
- vblank, out, 1.
- hsync, out, 1: active high.
- vsync, out, 1: active high.
- line_start, out, 1: one-ce pulse.
- frame_start, out, 1: one-ce pulse.
- line_irq, out, 1: optional feature.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge, regardless of ce_pix):
  - hcnt=0, vcnt=0.
  - hblank=vblank=0, hsync=vsync=0.
  - rgb_out=0, line_start=frame_start=line_irq=0.
  - Latched offsets are set to 0.
- Counting, on each ce_pix:
  - If hcnt < H_TOTAL-1: hcnt++.
  - Else: hcnt=0, and vcnt = (vcnt==V_TOTAL-1) ? 0 : vcnt+1.
- hpos and vpos are combinational from the counters.
- Offset latch: hoffs/voffs are sign-extended and captured only at the frame wrap, i.e. the ce where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1. Mid-frame changes have no effect until the next frame.
- Effective sync start positions:
  - HSB = H_SYNC_BEG + hoff_l, clamped to [0, H_TOTAL-H_SYNC_LEN].
  - VSB = V_SYNC_BEG + voff_l, clamped to [0, V_TOTAL-V_SYNC_LEN].
  - Compute in signed HW+2 / VW+2 bits so no wrap-around occurs before clamping.
- Registered outputs update on ce_pix from the pre-increment counter values, giving 1-ce latency:
  - hblank <= (hcnt < H_ACT_BEG) | (hcnt >= H_ACT_END).
  - vblank <= (vcnt >= V_ACT_END).
  - hsync <= (hcnt >= HSB) & (hcnt < HSB+H_SYNC_LEN).
  - vsync <= (vcnt >= VSB) & (vcnt < VSB+V_SYNC_LEN).
  - rgb_out <= (hblank|vblank) ? 0 : rgb_in. This uses the already-registered blank flags, giving 2-ce pixel alignment identical to the previous generation.
  - line_start <= (hcnt==H_TOTAL-1).
  - frame_start <= (hcnt==H_TOTAL-1) & (vcnt==V_TOTAL-1).
- Strobes are single-ce wide and are held, not cleared, between ce_pix pulses.
- ce_pix=0: all state is held.

Optional Feature:
- Macro: VIDEO_TIMING_LINE_IRQ_EN.
- With the macro defined:
  - line_irq <= (hcnt==H_TOTAL-1) & (next vcnt == irq_line), as a one-ce pulse.
  - irq_line >= V_TOTAL never fires.
  - irq_line is sampled every line, not latched.
- Without the macro: line_irq is tied to 0, irq_line is unused, and no comparator logic is generated.

Test Plan:
- Defaults, ce_pix every 8th clk, hoffs=voffs=0:
  - 396 ce per line, 256 lines per frame.
  - frame_start period = 101376 ce.
  - hsync high for hcnt 320..350, appearing 1 ce later.
  - vsync on lines 226..230.
- Blanking/RGB with rgb_in=12'hFFF:
  - rgb_out nonzero only for registered hcnt 25..264 on lines 0..223.
  - hpos=0 at hcnt=24.
  - rgb_out=0 throughout line 224.
- Offsets:
  - hoffs=-16 set mid-frame: hsync stays at 320 for the current frame and starts at 304 from the frame after frame_start.
  - voffs=+7: vsync on lines 233..237.
- Clamp: H_SYNC_BEG=370 and hoffs=+15 → HSB clamps to 365; hsync covers 365..395 with no wrap to line start.
- Reset mid-line at hcnt=200, vcnt=100, held for 1 clk with ce_pix=0: next ce shows hcnt=1, vcnt=0, and all outputs were 0 during reset.
- With VIDEO_TIMING_LINE_IRQ_EN:
  - irq_line=16 → one line_irq pulse per frame, coincident with the line_start into line 16.
  - irq_line=300 → never fires.
